power_seq: RTL and testbench

POWER_SEQ -- requirements
Module: power_seq

---
 rtl/power_seq.sv | 279 +++++++++++++++++++++++++++
 tb/tb_power_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/power_seq.sv
// power_seq: board power sequencer for NUM_RAILS supply rails.
//
// Rails are brought up in order 0..NUM_RAILS-1. Each rail gets PG_TIMEOUT
// ce_8hz ticks to report power-good, then STEP_DELAY ce_8hz ticks to settle
// before the next rail is enabled. Rails are shut down in reverse order, one
// per ce_8hz tick. A long press of the power button (LONG_PRESS_DELAY ce_1hz
// ticks) arms power-off, which begins when the button is released. A
// power-good failure drops every rail at once and latches the fault flag.
//
// Ports
//   clk             in   system clock, all logic on posedge
//   rst_n           in   asynchronous active-low reset
//   ce_1hz          in   single-cycle 1 Hz clock enable (button timing)
//   ce_8hz          in   single-cycle 8 Hz clock enable (rail timing)
//   start           in   board ready, leave WAIT
//   initial_pwr_off in   after start, go to POWER_OFF instead of ramping up
//   pwr_off         in   software power-off request (level)
//   pwr_on          in   software power-on request (level)
//   pwr_btn         in   debounced power button, active-high
//   pg              in   per-rail power-good, bit k for rail k
//   rail_en         out  registered per-rail enable
//   pwr_enable      out  high only while in POWER_ON
//   fault           out  sticky power-good fault flag
//
// State         | meaning
// --------------+-------------------------------------------------------
// S_WAIT        | after reset, waiting for start
// S_RAMP_UP     | enabling rails in order, waiting for pg then settling
// S_POWER_ON    | all rails up and healthy
// S_OFF_PENDING | button held, counting ce_1hz toward a long press
// S_OFF_WAIT    | long press reached, waiting for button release
// S_RAMP_DOWN   | disabling rails in reverse order, one per ce_8hz
// S_POWER_OFF   | all rails off, waiting for power-on request
// S_FAULT       | power-good failure, rails dropped, fault latched

module power_seq #(
  parameter int         NUM_RAILS        = 4,
  parameter logic [2:0] LONG_PRESS_DELAY = 3'd3,
  parameter logic [2:0] STEP_DELAY       = 3'd2,
  parameter logic [2:0] PG_TIMEOUT       = 3'd4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce_1hz,
  input  logic                 ce_8hz,
  input  logic                 start,
  input  logic                 initial_pwr_off,
  input  logic                 pwr_off,
  input  logic                 pwr_on,
  input  logic                 pwr_btn,
  input  logic [NUM_RAILS-1:0] pg,
  output logic [NUM_RAILS-1:0] rail_en,
  output logic                 pwr_enable,
  output logic                 fault
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_RAMP_UP,
    S_POWER_ON,
    S_OFF_PENDING,
    S_OFF_WAIT,
    S_RAMP_DOWN,
    S_POWER_OFF,
    S_FAULT
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(NUM_RAILS - 1);

  state_t               r_state;
  logic [2:0]           r_idx;
  logic [2:0]           r_timer;
  logic                 r_settle;
  logic [2:0]           r_press;
  logic [NUM_RAILS-1:0] r_rail_en;
  logic                 r_pwr_enable;
  logic                 r_fault;

  state_t               w_state_nxt;
  logic [2:0]           w_idx_nxt;
  logic [2:0]           w_timer_nxt;
  logic                 w_settle_nxt;
  logic [2:0]           w_press_nxt;
  logic [NUM_RAILS-1:0] w_rail_en_nxt;
  logic                 w_fault_nxt;

  // One-hot mask of the current rail; avoids variable bit-selects whose
  // index width would depend on NUM_RAILS.
  logic [NUM_RAILS-1:0] w_idx_mask;
  logic [NUM_RAILS-1:0] w_lower_mask;
  logic                 w_pg_cur;
  logic                 w_pg_lower_bad;
  logic                 w_pg_any_low;
  logic                 w_pg_all_low;
  logic [2:0]           w_timer_inc;
  logic [2:0]           w_press_inc;

  assign w_idx_mask     = NUM_RAILS'(1) << r_idx;
  assign w_lower_mask   = w_idx_mask - NUM_RAILS'(1);
  assign w_pg_cur       = |(pg & w_idx_mask);
  assign w_pg_lower_bad = ((pg & w_lower_mask) != w_lower_mask);
  assign w_pg_any_low   = ~&pg;
  assign w_pg_all_low   = (pg == '0);
  assign w_timer_inc    = r_timer + 3'd1;
  assign w_press_inc    = r_press + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_WAIT;
      r_idx        <= 3'd0;
      r_timer      <= 3'd0;
      r_settle     <= 1'b0;
      r_press      <= 3'd0;
      r_rail_en    <= '0;
      r_pwr_enable <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_timer      <= w_timer_nxt;
      r_settle     <= w_settle_nxt;
      r_press      <= w_press_nxt;
      r_rail_en    <= w_rail_en_nxt;
      r_pwr_enable <= (w_state_nxt == S_POWER_ON);
      r_fault      <= w_fault_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_timer_nxt   = r_timer;
    w_settle_nxt  = r_settle;
    w_press_nxt   = r_press;
    w_rail_en_nxt = r_rail_en;
    w_fault_nxt   = r_fault;

    case (r_state)
      S_WAIT: begin
        if (start) begin
          if (initial_pwr_off) begin
            w_state_nxt = S_POWER_OFF;
          end else begin
            w_state_nxt   = S_RAMP_UP;
            w_idx_nxt     = 3'd0;
            w_timer_nxt   = 3'd0;
            w_settle_nxt  = 1'b0;
            w_rail_en_nxt = NUM_RAILS'(1);
          end
        end
      end

      S_RAMP_UP: begin
        if (pwr_off) begin
          // Ramp down from whatever rail we reached; idx already points at
          // the highest enabled rail.
          w_state_nxt  = S_RAMP_DOWN;
          w_settle_nxt = 1'b0;
          w_timer_nxt  = 3'd0;
        end else if (w_pg_lower_bad || (r_settle && !w_pg_cur)) begin
          w_state_nxt   = S_FAULT;
          w_rail_en_nxt = '0;
          w_fault_nxt   = 1'b1;
          w_settle_nxt  = 1'b0;
          w_timer_nxt   = 3'd0;
        end else if (!r_settle) begin
          if (w_pg_cur) begin
            w_settle_nxt = 1'b1;
            w_timer_nxt  = 3'd0;
          end else if (ce_8hz) begin
            w_timer_nxt = w_timer_inc;
            if (w_timer_inc == PG_TIMEOUT) begin
              w_state_nxt   = S_FAULT;
              w_rail_en_nxt = '0;
              w_fault_nxt   = 1'b1;
              w_timer_nxt   = 3'd0;
            end
          end
        end else if (ce_8hz) begin
          w_timer_nxt = w_timer_inc;
          if (w_timer_inc == STEP_DELAY) begin
            w_timer_nxt  = 3'd0;
            w_settle_nxt = 1'b0;
            if (r_idx == LAST_IDX) begin
              w_state_nxt = S_POWER_ON;
            end else begin
              w_idx_nxt     = r_idx + 3'd1;
              w_rail_en_nxt = r_rail_en | (w_idx_mask << 1);
            end
          end
        end
      end

      S_POWER_ON: begin
        if (w_pg_any_low) begin
          w_state_nxt   = S_FAULT;
          w_rail_en_nxt = '0;
          w_fault_nxt   = 1'b1;
        end else if (pwr_off) begin
          w_state_nxt = S_RAMP_DOWN;
        end else if (pwr_btn) begin
          w_state_nxt = S_OFF_PENDING;
          w_press_nxt = 3'd0;
        end
      end

      S_OFF_PENDING: begin
        if (w_pg_any_low) begin
          w_state_nxt   = S_FAULT;
          w_rail_en_nxt = '0;
          w_fault_nxt   = 1'b1;
        end else if (pwr_off) begin
          w_state_nxt = S_RAMP_DOWN;
        end else if (!pwr_btn) begin
          w_state_nxt = S_POWER_ON;
        end else if (r_press == LONG_PRESS_DELAY) begin
          w_state_nxt = S_OFF_WAIT;
        end else if (ce_1hz) begin
          w_press_nxt = w_press_inc;
        end
      end

      S_OFF_WAIT: begin
        if (w_pg_any_low) begin
          w_state_nxt   = S_FAULT;
          w_rail_en_nxt = '0;
          w_fault_nxt   = 1'b1;
        end else if (!pwr_btn) begin
          w_state_nxt = S_RAMP_DOWN;
        end
      end

      S_RAMP_DOWN: begin
        if (ce_8hz) begin
          w_rail_en_nxt = r_rail_en & ~w_idx_mask;
          if (r_idx == 3'd0) begin
            w_state_nxt = S_POWER_OFF;
          end else begin
            w_idx_nxt = r_idx - 3'd1;
          end
        end
      end

      S_POWER_OFF: begin
        w_rail_en_nxt = '0;
        if (pwr_on || pwr_btn) begin
          w_state_nxt   = S_RAMP_UP;
          w_idx_nxt     = 3'd0;
          w_timer_nxt   = 3'd0;
          w_settle_nxt  = 1'b0;
          w_rail_en_nxt = NUM_RAILS'(1);
        end
      end

      S_FAULT: begin
        w_rail_en_nxt = '0;
        // Restart only once every rail has actually discharged.
        if ((pwr_on || pwr_btn) && w_pg_all_low) begin
          w_state_nxt   = S_RAMP_UP;
          w_idx_nxt     = 3'd0;
          w_timer_nxt   = 3'd0;
          w_settle_nxt  = 1'b0;
          w_rail_en_nxt = NUM_RAILS'(1);
          w_fault_nxt   = 1'b0;
        end
      end

      default: begin
        w_state_nxt   = S_WAIT;
        w_rail_en_nxt = '0;
      end
    endcase
  end

  assign rail_en    = r_rail_en;
  assign pwr_enable = r_pwr_enable;
  assign fault      = r_fault;

endmodule

// File: tb/tb_power_seq.sv
module tb_power_seq;

  logic       clk;
  logic       rst_n;
  logic       ce_1hz;
  logic       ce_8hz;
  logic       start;
  logic       initial_pwr_off;
  logic       pwr_off;
  logic       pwr_on;
  logic       pwr_btn;
  logic [2:0] pg;
  logic [2:0] rail_en;
  logic       pwr_enable;
  logic       fault;

  int checks = 0;
  int errors = 0;

  power_seq #(
    .NUM_RAILS       (3),
    .LONG_PRESS_DELAY(3'd3),
    .STEP_DELAY      (3'd2),
    .PG_TIMEOUT      (3'd4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ce_1hz         (ce_1hz),
    .ce_8hz         (ce_8hz),
    .start          (start),
    .initial_pwr_off(initial_pwr_off),
    .pwr_off        (pwr_off),
    .pwr_on         (pwr_on),
    .pwr_btn        (pwr_btn),
    .pg             (pg),
    .rail_en        (rail_en),
    .pwr_enable     (pwr_enable),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ce8();
    ce_8hz = 1'b1;
    cyc(1);
    ce_8hz = 1'b0;
  endtask

  task automatic ce1();
    ce_1hz = 1'b1;
    cyc(1);
    ce_1hz = 1'b0;
  endtask

  // From RAMP_UP with rail_en=001 just set: raise each pg one ce_8hz after
  // its enable, then allow two settle ticks.
  task automatic ramp_up_all();
    logic [2:0] exp_en;
    for (int k = 0; k < 3; k++) begin
      ce8();
      pg = pg | (3'b001 << k);
      cyc(1);
      ce8();
      chk("settle_mid", {5'd0, rail_en}, {5'd0, (k == 0) ? 3'b001 : (k == 1) ? 3'b011 : 3'b111});
      ce8();
      exp_en = (k == 0) ? 3'b011 : 3'b111;
      chk("ramp_en", {5'd0, rail_en}, {5'd0, exp_en});
      chk("ramp_pwr_enable", {7'd0, pwr_enable}, {7'd0, (k == 2)});
    end
  endtask

  initial begin
    rst_n = 1'b0; ce_1hz = 1'b0; ce_8hz = 1'b0; start = 1'b0;
    initial_pwr_off = 1'b0; pwr_off = 1'b0; pwr_on = 1'b0; pwr_btn = 1'b0;
    pg = 3'b000;
    cyc(3);
    chk("rst_rail_en", {5'd0, rail_en}, 8'h00);
    chk("rst_pwr_enable", {7'd0, pwr_enable}, 8'h00);
    chk("rst_fault", {7'd0, fault}, 8'h00);
    rst_n = 1'b1;
    cyc(3);
    chk("wait_hold", {5'd0, rail_en}, 8'h00);

    // Normal ramp up
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("ramp_entry", {5'd0, rail_en}, 8'h01);
    ramp_up_all();

    // Short press returns to POWER_ON
    pwr_btn = 1'b1;
    cyc(1);
    chk("off_pend_pwr_enable", {7'd0, pwr_enable}, 8'h00);
    ce1();
    ce_8hz = 1'b1; // simultaneous enables: 1 Hz must still count
    ce1();
    ce_8hz = 1'b0;
    pwr_btn = 1'b0;
    cyc(1);
    chk("short_press_on", {7'd0, pwr_enable}, 8'h01);
    chk("short_press_rails", {5'd0, rail_en}, 8'h07);

    // Long press, then release: reverse ramp down
    pwr_btn = 1'b1;
    cyc(1);
    ce1(); ce1(); ce1();
    cyc(2);
    chk("off_wait_rails", {5'd0, rail_en}, 8'h07);
    chk("off_wait_pwr_enable", {7'd0, pwr_enable}, 8'h00);
    pwr_btn = 1'b0;
    cyc(1);
    chk("rdown_entry", {5'd0, rail_en}, 8'h07);
    ce8();
    chk("rdown_1", {5'd0, rail_en}, 8'h03);
    ce8();
    chk("rdown_2", {5'd0, rail_en}, 8'h01);
    ce8();
    chk("rdown_3", {5'd0, rail_en}, 8'h00);
    pg = 3'b000;
    cyc(2);
    chk("power_off_hold", {5'd0, rail_en}, 8'h00);

    // pg[1] timeout
    pwr_on = 1'b1;
    cyc(1);
    pwr_on = 1'b0;
    chk("pon_entry", {5'd0, rail_en}, 8'h01);
    ce8();
    pg = 3'b001;
    cyc(1);
    ce8(); ce8();
    chk("to_rail1", {5'd0, rail_en}, 8'h03);
    ce8(); ce8(); ce8();
    chk("to_3ticks_rails", {5'd0, rail_en}, 8'h03);
    chk("to_3ticks_fault", {7'd0, fault}, 8'h00);
    ce8();
    chk("to_fault_rails", {5'd0, rail_en}, 8'h00);
    chk("to_fault_flag", {7'd0, fault}, 8'h01);
    chk("to_fault_pwr_enable", {7'd0, pwr_enable}, 8'h00);
    pwr_btn = 1'b1;
    cyc(1);
    pwr_btn = 1'b0;
    chk("fault_hold_pg", {7'd0, fault}, 8'h01);
    pg = 3'b000;
    cyc(1);
    chk("fault_sticky", {7'd0, fault}, 8'h01);
    pwr_btn = 1'b1;
    cyc(1);
    pwr_btn = 1'b0;
    chk("fault_exit_flag", {7'd0, fault}, 8'h00);
    chk("fault_exit_rails", {5'd0, rail_en}, 8'h01);

    // POWER_ON pg glitch
    ramp_up_all();
    pg = 3'b110;
    cyc(1);
    pg = 3'b111;
    chk("glitch_rails", {5'd0, rail_en}, 8'h00);
    chk("glitch_fault", {7'd0, fault}, 8'h01);
    pwr_btn = 1'b1;
    cyc(1);
    pwr_btn = 1'b0;
    chk("glitch_hold", {7'd0, fault}, 8'h01);
    pg = 3'b000;
    pwr_btn = 1'b1;
    cyc(1);
    pwr_btn = 1'b0;
    chk("glitch_exit_fault", {7'd0, fault}, 8'h00);
    chk("glitch_exit_rails", {5'd0, rail_en}, 8'h01);

    // pwr_off during RAMP_UP
    ce8();
    pg = 3'b001;
    cyc(1);
    ce8(); ce8();
    pwr_off = 1'b1;
    cyc(1);
    pwr_off = 1'b0;
    pg = 3'b000;
    cyc(1);
    chk("abort_rails", {5'd0, rail_en}, 8'h03);
    chk("abort_no_fault", {7'd0, fault}, 8'h00);
    ce8();
    chk("abort_down1", {5'd0, rail_en}, 8'h01);
    ce8();
    chk("abort_down2", {5'd0, rail_en}, 8'h00);

    // Async reset mid ramp
    pwr_on = 1'b1;
    cyc(1);
    pwr_on = 1'b0;
    ce8();
    pg = 3'b001;
    cyc(1);
    ce8(); ce8();
    chk("prerst_rails", {5'd0, rail_en}, 8'h03);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rails", {5'd0, rail_en}, 8'h00);
    chk("async_rst_fault", {7'd0, fault}, 8'h00);
    cyc(1);
    pg = 3'b000;
    rst_n = 1'b1;
    pwr_on = 1'b1;
    cyc(3);
    pwr_on = 1'b0;
    chk("post_rst_wait", {5'd0, rail_en}, 8'h00);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("post_rst_start", {5'd0, rail_en}, 8'h01);

    // initial_pwr_off path
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    start = 1'b1;
    initial_pwr_off = 1'b1;
    cyc(1);
    start = 1'b0;
    initial_pwr_off = 1'b0;
    cyc(2);
    chk("ipo_rails", {5'd0, rail_en}, 8'h00);
    chk("ipo_pwr_enable", {7'd0, pwr_enable}, 8'h00);
    pwr_on = 1'b1;
    cyc(1);
    pwr_on = 1'b0;
    chk("ipo_pwr_on", {5'd0, rail_en}, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
